// File: rtl/mcp3008_pkg.sv
// mcp3008_pkg: shared types, frame geometry and channel helpers
// for the MCP3008 round-robin scanner.
package mcp3008_pkg;

  localparam int FRAME_BITS      = 17;
  localparam int CMD_BITS        = 5;
  localparam int DATA_FIRST_EDGE = 8;
  localparam int ADC_BITS        = 10;
  localparam int NUM_CH          = 8;

  typedef logic [2:0] ch_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } state_t;

  // Next set channel strictly after cur, wrapping 7 -> 0.
  // An empty mask leaves the pointer where it is.
  function automatic ch_t next_ch(
    input ch_t        cur,
    input logic [7:0] mask
  );
    ch_t  res;
    ch_t  c;
    logic found;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = ch_t'(cur + ch_t'(i));
      if (!found && mask[c]) begin
        res   = c;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Highest set channel: the last one of a scan.
  function automatic ch_t top_ch(
    input logic [7:0] mask
  );
    ch_t res;
    res = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) res = ch_t'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// sclk_tick_gen: half-period tick for the SPI clock.
// Ports: clk, rst_n, run (count enable), tick (one-clk strobe).
module sclk_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Held at zero while idle so a frame
  // always starts on a full half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/mcp3008_scanner.sv
// mcp3008_scanner: continuous masked channel scanner for an MCP3008 (SPI 0,0).
// Ports: enable/ch_mask, sclk/cs_n/din/dout, sample_* strobe, scan_done, results.
module mcp3008_scanner
  import mcp3008_pkg::*;
#(
  parameter int CLK_DIV      = 25,
  parameter int CS_GAP       = 2,
  parameter bit SINGLE_ENDED = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          ch_mask,
  output logic                       sclk,
  output logic                       cs_n,
  output logic                       din,
  input  logic                       dout,
  output logic [ADC_BITS-1:0]        sample_data,
  output ch_t                        sample_ch,
  output logic                       sample_valid,
  output logic                       scan_done,
  output logic [NUM_CH*ADC_BITS-1:0] results
);

  // hp_q counts half-periods inside SHIFT and GAP.
  // In SHIFT even hp is sclk low, odd hp is sclk high;
  // rising edge k happens leaving hp 2k-2.
  localparam logic [5:0] HP_LAST =
    6'(2 * FRAME_BITS - 1);
  localparam logic [5:0] CAP_FIRST =
    6'(2 * DATA_FIRST_EDGE - 2);
  localparam logic [5:0] CAP_LAST =
    6'(2 * FRAME_BITS - 2);
  localparam logic [5:0] GAP_LAST =
    6'(CS_GAP - 1);

  state_t state_q;
  state_t state_d;

  logic                      tick;
  logic                      run;
  logic                      go;
  logic                      sh_tick;
  logic [5:0]                hp_q;
  ch_t                       ch_q;
  logic [ADC_BITS-1:0]       sh_q;
  logic                      last_q;
  logic [CMD_BITS-1:0]       cmd;
  logic [4:0]                bidx;
  logic                      cmd_bit;
  logic [NUM_CH-1:0][ADC_BITS-1:0] res_q;

  assign run     = (state_q != IDLE);
  assign go      = enable && (ch_mask != '0);
  assign sh_tick = tick && (state_q == SHIFT);
  assign results = res_q;

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go) state_d = SETUP;
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick && hp_q == HP_LAST)
          state_d = GAP;
      end
      GAP: begin
        if (tick && hp_q == GAP_LAST)
          state_d = go ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Start, SGL/DIFF, D2..D0; each bit is held
  // for a full sclk period starting low.
  assign cmd  = {1'b1, SINGLE_ENDED, ch_q};
  assign bidx = hp_q[5:1];

  always_comb begin
    cmd_bit = 1'b0;
    if (bidx < 5'(CMD_BITS))
      cmd_bit = cmd[3'(CMD_BITS - 1) - bidx[2:0]];
  end

  always_comb begin
    cs_n = 1'b1;
    sclk = 1'b0;
    din  = 1'b0;
    unique case (state_q)
      SETUP: begin
        cs_n = 1'b0;
        din  = 1'b1;
      end
      SHIFT: begin
        cs_n = 1'b0;
        sclk = hp_q[0];
        din  = cmd_bit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_q         <= '0;
      ch_q         <= '0;
      sh_q         <= '0;
      last_q       <= 1'b0;
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      res_q        <= '0;
    end else begin
      last_q       <= 1'b0;
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;

      if (state_d != state_q) begin
        hp_q <= '0;
      end else if (tick) begin
        hp_q <= hp_q + 6'd1;
      end

      // Leaving idle: keep the pointer if its
      // channel is selected, else move on.
      if (state_q == IDLE && go &&
          !ch_mask[ch_q])
        ch_q <= next_ch(ch_q, ch_mask);

      // Rising sclk: edge 7 is the null bit.
      if (sh_tick && !hp_q[0]) begin
        if (hp_q >= CAP_FIRST)
          sh_q <= {sh_q[ADC_BITS-2:0], dout};
        last_q <= (hp_q == CAP_LAST);
      end

      if (sh_tick && hp_q == HP_LAST)
        ch_q <= next_ch(ch_q, ch_mask);

      if (last_q) begin
        sample_valid <= 1'b1;
        sample_data  <= sh_q;
        sample_ch    <= ch_q;
        res_q[ch_q]  <= sh_q;
        scan_done    <= (ch_q == top_ch(ch_mask));
      end
    end
  end

endmodule

// File: tb/tb_mcp3008_scanner.sv
// tb_mcp3008_scanner: MCP3008 behavioural model plus directed scenarios
// for the masked channel scanner at default and fast clock divisors.
`timescale 1ns/1ps
module tb_mcp3008_scanner;

  localparam int CLK_DIV = 25;
  localparam int CS_GAP  = 2;
  localparam int FRAME   = (1 + 34 + CS_GAP) * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  ch_mask;
  logic        sclk, cs_n, din;
  logic        dout;
  logic [9:0]  sample_data;
  logic [2:0]  sample_ch;
  logic        sample_valid, scan_done;
  logic [79:0] results;

  logic        enable2;
  logic [7:0]  ch_mask2 = 8'h01;
  logic        dout2 = 1'b1;
  logic        sclk2, cs_n2, din2;
  logic [9:0]  sample_data2;
  logic [2:0]  sample_ch2;
  logic        sample_valid2, scan_done2;
  logic [79:0] results2;

  mcp3008_scanner u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .din          (din),
    .dout         (dout),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .scan_done    (scan_done),
    .results      (results)
  );

  mcp3008_scanner #(
    .CLK_DIV      (4),
    .CS_GAP       (3),
    .SINGLE_ENDED (1'b1)
  ) u_dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable2),
    .ch_mask      (ch_mask2),
    .sclk         (sclk2),
    .cs_n         (cs_n2),
    .din          (din2),
    .dout         (dout2),
    .sample_data  (sample_data2),
    .sample_ch    (sample_ch2),
    .sample_valid (sample_valid2),
    .scan_done    (scan_done2),
    .results      (results2)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int hi_ch(input logic [7:0] m);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++)
      if (m[i]) r = i;
    return r;
  endfunction

  // ADC model: decodes the command from din on sclk rises,
  // shifts the stored value out on sclk falls (null after edge 6).
  logic [9:0] adc [8];
  int         edges = 0;
  logic [4:0] cmd, last_cmd;
  logic       tail_ok;
  logic [2:0] m_ch = '0;
  logic [9:0] m_val = '0;
  int         v17 = -100;
  int         rise_c, fall_c, csf_c, csr_c;
  logic       sclk_p = 1'b0;
  logic       cs_p = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      edges  = 0;
      dout   = 1'b0;
      sclk_p = 1'b0;
      cs_p   = 1'b1;
    end else begin
      if (cs_p && !cs_n) begin
        edges   = 0;
        tail_ok = 1'b1;
        csf_c   = cyc;
      end
      if (!sclk_p && sclk) begin
        edges++;
        if (edges == 1)
          chk("setup_len", cyc - csf_c, 2 * CLK_DIV);
        else
          chk("sclk_low", cyc - fall_c, CLK_DIV);
        rise_c = cyc;
        if (edges <= 5) cmd[5 - edges] = din;
        else if (din) tail_ok = 1'b0;
        if (edges == 5) begin
          m_ch  = cmd[2:0];
          m_val = adc[m_ch];
        end
        if (edges == 17) begin
          chk("cmd_format",
              int'({cmd[4:3], tail_ok}), 7);
          last_cmd = cmd;
          v17      = cyc;
        end
      end
      if (sclk_p && !sclk) begin
        chk("sclk_high", cyc - rise_c, CLK_DIV);
        fall_c = cyc;
        if (edges >= 7 && edges <= 16)
          dout = m_val[16 - edges];
        else
          dout = 1'b0;
      end
      if (!cs_p && cs_n) begin
        csr_c = cyc;
        edges = 0;
        dout  = 1'b0;
      end
      sclk_p = sclk;
      cs_p   = cs_n;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic ev;
    if (rst_n) begin
      ev = (cyc == v17 + 1);
      chk("sample_valid", int'(sample_valid), int'(ev));
      if (ev) begin
        chk("sample_ch", int'(sample_ch), int'(m_ch));
        chk("sample_data", int'(sample_data), int'(m_val));
        chk("scan_done", int'(scan_done),
            int'(int'(m_ch) == hi_ch(ch_mask)));
        chk("results_slot",
            int'(results[m_ch*10 +: 10]), int'(m_val));
      end else begin
        chk("scan_done_quiet", int'(scan_done), 0);
      end
      if (cs_n) chk("idle_sclk", int'(sclk), 0);
    end
  end

  task automatic wait_sv(output int c);
    c = -1;
    for (int n = 0; n < 3 * FRAME; n++) begin
      @(negedge clk);
      if (sample_valid) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("sv_timeout", 0, 1);
  endtask

  task automatic wait_edges(input int k);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 3 * FRAME; n++) begin
      @(negedge clk);
      if (edges == k) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("edge_timeout", 0, 1);
  endtask

  task automatic wait_lvl(input int which,
                          input logic lvl,
                          output int t);
    logic s;
    t = -1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      s = (which == 0) ? cs_n2 : sclk2;
      if (s == lvl) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("lvl_timeout", which, -1);
  endtask

  task automatic quiet(input int n, output int busy);
    busy = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sclk || !cs_n) busy++;
    end
  endtask

  logic [2:0] e_ch [4] = '{3'd2, 3'd5, 3'd7, 3'd2};
  logic [9:0] e_d  [4] =
    '{10'h001, 10'h200, 10'h3FF, 10'h001};
  logic       e_sd [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int c1, c2, busy, n;
    int t0, t1, t2, t3, t4, t5;
    logic [79:0] er;

    rst_n   = 1'b0;
    enable  = 1'b0;
    enable2 = 1'b0;
    ch_mask = 8'h00;
    adc[0] = 10'h2A5; adc[1] = 10'h011;
    adc[2] = 10'h001; adc[3] = 10'h155;
    adc[4] = 10'h0F0; adc[5] = 10'h200;
    adc[6] = 10'h0AA; adc[7] = 10'h3FF;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_done", int'(scan_done), 0);
    chk("rst_data", int'(sample_data), 0);
    chk("rst_ch", int'(sample_ch), 0);
    chk("rst_results", int'(results == '0), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single channel 0.
    ch_mask = 8'h01;
    enable  = 1'b1;
    wait_sv(c1);
    chk("s1_ch", int'(sample_ch), 0);
    chk("s1_data", int'(sample_data), 'h2A5);
    chk("s1_done", int'(scan_done), 1);
    chk("s1_din_seq", int'(last_cmd), 'b11000);
    wait_sv(c2);
    chk("s1_period", c2 - c1, 925);
    chk("s1_done2", int'(scan_done), 1);
    chk("s1_cs_gap", csf_c - csr_c, 50);
    @(negedge clk);
    enable = 1'b0;
    repeat ((CS_GAP + 2) * CLK_DIV) @(negedge clk);
    chk("s1_idle", int'(cs_n), 1);

    // Mask A4: order 2,5,7,2.
    ch_mask = 8'hA4;
    enable  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_sv(c1);
      chk("s2_ch", int'(sample_ch), int'(e_ch[i]));
      chk("s2_data", int'(sample_data), int'(e_d[i]));
      chk("s2_done", int'(scan_done), int'(e_sd[i]));
    end
    @(negedge clk);
    enable = 1'b0;
    repeat ((CS_GAP + 2) * CLK_DIV) @(negedge clk);
    chk("s2_slot2", int'(results[29:20]), 'h001);
    chk("s2_slot5", int'(results[59:50]), 'h200);
    chk("s2_slot7", int'(results[79:70]), 'h3FF);
    chk("s2_slot0", int'(results[9:0]), 'h2A5);

    // Enable dropped mid-frame on channel 3.
    ch_mask = 8'h08;
    enable  = 1'b1;
    wait_edges(10);
    enable = 1'b0;
    wait_sv(c1);
    chk("s3_ch", int'(sample_ch), 3);
    chk("s3_data", int'(sample_data), 'h155);
    repeat ((CS_GAP + 2) * CLK_DIV) @(negedge clk);
    quiet(300, busy);
    chk("s3_stay_idle", busy, 0);

    // Reset at edge 12.
    enable = 1'b1;
    wait_edges(12);
    rst_n = 1'b0;
    #1;
    chk("s4_cs_async", int'(cs_n), 1);
    chk("s4_sclk_async", int'(sclk), 0);
    repeat (3) begin
      @(negedge clk);
      chk("s4_no_valid", int'(sample_valid), 0);
    end
    chk("s4_results", int'(results == '0), 1);
    chk("s4_data", int'(sample_data), 0);
    rst_n = 1'b1;
    wait_sv(c1);
    chk("s4_ch", int'(sample_ch), 3);
    chk("s4_restart_data", int'(sample_data), 'h155);
    er = '0;
    er[39:30] = 10'h155;
    chk("s4_results_after", int'(results == er), 1);

    // Empty mask keeps the block idle.
    @(negedge clk);
    ch_mask = 8'h00;
    repeat ((CS_GAP + 2) * CLK_DIV) @(negedge clk);
    quiet(5000, busy);
    chk("s5_mask0_idle", busy, 0);
    ch_mask = 8'h10;
    n = 0;
    while (cs_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s5_start_latency", int'(n <= CLK_DIV + 1), 1);
    wait_sv(c1);
    chk("s5_ch", int'(sample_ch), 4);
    chk("s5_data", int'(sample_data), 'h0F0);
    chk("s5_done", int'(scan_done), 1);
    @(negedge clk);
    enable = 1'b0;
    repeat ((CS_GAP + 2) * CLK_DIV) @(negedge clk);

    // Fast divisor instance: CLK_DIV=4, CS_GAP=3.
    enable2 = 1'b1;
    wait_lvl(0, 1'b0, t0);
    wait_lvl(1, 1'b1, t1);
    wait_lvl(1, 1'b0, t2);
    wait_lvl(1, 1'b1, t3);
    wait_lvl(0, 1'b1, t4);
    wait_lvl(0, 1'b0, t5);
    chk("s6_first_rise", t1 - t0, 8);
    chk("s6_high", t2 - t1, 4);
    chk("s6_low", t3 - t2, 4);
    chk("s6_gap", t5 - t4, 12);
    chk("s6_frame", t5 - t0, 152);
    chk("s6_data", int'(sample_data2), 'h3FF);
    chk("s6_ch", int'(sample_ch2), 0);
    enable2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
